// File: rtl/intr_arb.sv
// rtl/intr_arb.sv - priority interrupt arbiter: request latch, CPU handshake, bus grant, vector capture
//
// Purpose:
//    Registers the seven level-sensitive device requests and presents them to the
//    external priority comparator. When the CPU acknowledges at an instruction boundary, it
//    grants the bus to the highest pending level above the processor priority, captures the
//    device vector and hands it to the CPU. A grant ends without a vector (abort strobe) if
//    the device releases its request.
//
// Optional feature (macro INTR_TIMEOUT_EN):
//    When defined, a grant also aborts after TIMEOUT_CYCLES cycles without a vector.
//    When undefined, a grant waits indefinitely for a vector or a passive release.
//
// Ports:
//    clk            system clock, rising edge
//    reset_n        asynchronous active-low reset
//    irq[6:0]       device requests, irq[n-1] = level n
//    asserting[7:0] registered pending vector to comparator, bit 7 always 0
//    int_above      comparator: a pending level exceeds ipl
//    ipl[2:0]       current processor priority
//    cpu_int_req    interrupt request to CPU sequencer
//    cpu_int_ack    CPU accepts the interrupt (one-cycle pulse)
//    grant[6:0]     one-hot bus grant, grant[n-1] = level n
//    dev_vec_valid  device presents a vector this cycle
//    dev_vec[7:0]   device vector
//    cpu_vec[7:0]   captured vector to CPU
//    cpu_vec_valid  one-cycle strobe, cpu_vec valid
//    cpu_vec_abort  one-cycle strobe, grant ended without vector
//    win_level[2:0] level being serviced, 0 when idle

module intr_arb #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] irq,
   output logic [7:0] asserting,
   input  logic       int_above,
   input  logic [2:0] ipl,
   output logic       cpu_int_req,
   input  logic       cpu_int_ack,
   output logic [6:0] grant,
   input  logic       dev_vec_valid,
   input  logic [7:0] dev_vec,
   output logic [7:0] cpu_vec,
   output logic       cpu_vec_valid,
   output logic       cpu_vec_abort,
   output logic [2:0] win_level
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("intr_arb: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2,
      ABORT = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] pend_q, pend_d;
   logic [2:0] win_level_q, win_level_d;
   logic [7:0] cpu_vec_q, cpu_vec_d;

   logic [2:0] win_sel;     // highest pending level above ipl, 0 if none
   logic [6:0] level_oh;    // one-hot decode of the latched winning level
   logic       win_pend;    // winning device still holding its request
   logic       tmo_hit;     // last permitted grant cycle

`ifdef INTR_TIMEOUT_EN
   // Counts grant cycles 0..TIMEOUT_CYCLES-1; held at 0 outside GRANT so every grant
   // starts from zero.
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = '0;
      if (state_q == GRANT) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   assign tmo_hit = (state_q == GRANT) && (tmo_q == TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Requests are sampled every cycle regardless of state; the comparator sees the
   // registered copy so asserting lags irq by exactly one cycle.
   assign pend_d    = irq;
   assign asserting = {1'b0, pend_q};

   // Ascending scan: a later (higher) level overwrites a lower one.
   always_comb begin
      win_sel = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (pend_q[i] && (3'(i + 1) > ipl)) begin
            win_sel = 3'(i + 1);
         end
      end
   end

   always_comb begin
      level_oh = 7'd0;
      for (int i = 0; i < 7; i++) begin
         if (win_level_q == 3'(i + 1)) begin
            level_oh[i] = 1'b1;
         end
      end
   end

   assign win_pend = |(pend_q & level_oh);

   always_comb begin
      state_d     = state_q;
      win_level_d = win_level_q;
      cpu_vec_d   = cpu_vec_q;
      case (state_q)
         IDLE: begin
            // An ack without an outstanding request is ignored; a comparator that
            // claims int_above with nothing above ipl also cannot start a grant.
            if (cpu_int_ack && cpu_int_req && (win_sel != 3'd0)) begin
               win_level_d = win_sel;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            // A vector beats both passive release and timeout in the same cycle.
            if (dev_vec_valid) begin
               cpu_vec_d = dev_vec;
               state_d   = DONE;
            end else if (!win_pend || tmo_hit) begin
               state_d = ABORT;
            end
         end
         DONE: begin
            win_level_d = 3'd0;
            state_d     = IDLE;
         end
         ABORT: begin
            win_level_d = 3'd0;
            state_d     = IDLE;
         end
         default: begin
            win_level_d = 3'd0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pend_q      <= 7'd0;
         win_level_q <= 3'd0;
         cpu_vec_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         win_level_q <= win_level_d;
         cpu_vec_q   <= cpu_vec_d;
      end
   end

   // Outputs decode directly from registered state so reset clears them without
   // waiting for a clock edge.
   assign cpu_int_req   = (state_q == IDLE) && int_above && (pend_q != 7'd0);
   assign grant         = (state_q == GRANT) ? level_oh : 7'd0;
   assign cpu_vec       = cpu_vec_q;
   assign cpu_vec_valid = (state_q == DONE);
   assign cpu_vec_abort = (state_q == ABORT);
   assign win_level     = win_level_q;

endmodule
